// File: rtl/i2c_pkg.sv
// Shared constants for the I2C byte sequencer: FSM encoding, quarter indices, segment counts.
package i2c_pkg;
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_BIT   = 3'd2;
  localparam logic [2:0] S_ACK   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_HOLD  = 3'd5;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam int QTR_MIN   = 2;
  localparam int DATA_BITS = 8;
  localparam int SEG_QTRS  = 4;
  localparam int SEGS_BYTE = DATA_BITS + 1;
  localparam logic [2:0] BIT_MSB = 3'(DATA_BITS - 1);
endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-period prescaler: one-cycle tick every QTR clocks while running, plus 2-bit quarter index.
// A restart counts its own cycle as the first clock of quarter Q0.
module i2c_qtr_tick
  import i2c_pkg::*;
#(
  parameter int QTR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       restart,
  input  logic       run,
  output logic       tick,
  output logic [1:0] qtr
);
  logic [15:0] cnt;

  assign tick = run && (cnt == 16'(QTR - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      qtr <= Q0;
    end else if (restart) begin
      cnt <= 16'd1;
      qtr <= Q0;
    end else if (tick) begin
      cnt <= '0;
      qtr <= qtr + 2'd1;
    end else if (run) begin
      cnt <= cnt + 16'd1;
    end
  end
endmodule

// File: rtl/i2c_master_ctrl.sv
// Byte-level I2C master sequencer driving the BIU; one command per byte, rsp_valid 4*QTR*segments after accept.
// cmd_ready only in IDLE/HOLD. Define I2C_NACK_ABORT_EN to force STOP after a NACKed write.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int QTR = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_start,
  input  logic       cmd_stop,
  input  logic       cmd_read,
  input  logic       cmd_ack,
  input  logic [7:0] wr_data,
  output logic [7:0] rd_data,
  output logic       rsp_valid,
  output logic       rsp_nack,
  output logic       busy,
  output logic       iSCL,
  output logic       oSDA,
  output logic       en,
  input  logic       iSDA
);
  logic [2:0] state;
  logic [2:0] bit_idx;
  logic [7:0] c_data;
  logic       c_stop, c_read, c_ack, from_hold;
  logic       accept, run, tick, seg_end, sample, go_stop;
  logic [1:0] qtr;

  assign cmd_ready = (state == S_IDLE) || (state == S_HOLD);
  assign busy      = (state != S_IDLE);
  assign accept    = cmd_valid && cmd_ready;
  assign run       = (state == S_START) || (state == S_BIT) || (state == S_ACK) || (state == S_STOP);
  assign seg_end   = tick && (qtr == Q3);
  assign sample    = tick && (qtr == Q1);

`ifdef I2C_NACK_ABORT_EN
  assign go_stop = c_stop || (!c_read && rsp_nack);
`else
  assign go_stop = c_stop;
`endif

  i2c_qtr_tick #(.QTR(QTR)) u_tick (
    .clk     (clk),
    .rst     (rst),
    .restart (accept),
    .run     (run),
    .tick    (tick),
    .qtr     (qtr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_idx   <= BIT_MSB;
      c_data    <= '0;
      c_stop    <= 1'b0;
      c_read    <= 1'b0;
      c_ack     <= 1'b0;
      from_hold <= 1'b0;
      rd_data   <= '0;
      rsp_valid <= 1'b0;
      rsp_nack  <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        c_data    <= wr_data;
        c_stop    <= cmd_stop;
        c_read    <= cmd_read;
        c_ack     <= cmd_ack;
        bit_idx   <= BIT_MSB;
        from_hold <= (state == S_HOLD);
        rsp_nack  <= 1'b0;
        // An idle bus must be claimed with START even if the command did not ask for one.
        state     <= (cmd_start || state == S_IDLE) ? S_START : S_BIT;
      end else begin
        if (sample && c_read && state == S_BIT)
          rd_data <= {rd_data[6:0], iSDA};
        if (sample && !c_read && state == S_ACK)
          rsp_nack <= iSDA;
        if (seg_end) begin
          case (state)
            S_START: state <= S_BIT;
            S_BIT: begin
              if (bit_idx == 3'd0) state <= S_ACK;
              else bit_idx <= bit_idx - 3'd1;
            end
            S_ACK: begin
              if (go_stop) begin
                state <= S_STOP;
              end else begin
                state     <= S_HOLD;
                rsp_valid <= 1'b1;
              end
            end
            S_STOP: begin
              state     <= S_IDLE;
              rsp_valid <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    iSCL = 1'b1;
    oSDA = 1'b1;
    en   = 1'b1;
    case (state)
      S_START: begin
        iSCL = !((qtr == Q3) || (qtr == Q0 && from_hold));
        oSDA = (qtr == Q0) || (qtr == Q1);
      end
      S_BIT: begin
        iSCL = (qtr == Q1) || (qtr == Q2);
        if (c_read) en = 1'b0;
        else oSDA = c_data[bit_idx];
      end
      S_ACK: begin
        iSCL = (qtr == Q1) || (qtr == Q2);
        if (c_read) oSDA = c_ack;
        else en = 1'b0;
      end
      S_STOP: begin
        iSCL = (qtr != Q0);
        oSDA = (qtr == Q2) || (qtr == Q3);
      end
      S_HOLD: begin
        // Keep the level last driven in the ACK slot while SCL is parked low.
        iSCL = 1'b0;
        oSDA = c_read ? c_ack : 1'b1;
      end
      default: ;
    endcase
  end
endmodule
